// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared period counter and a
// per-channel duty compare. Period, duty and mode are double-buffered in shadow
// registers and committed only at a period boundary, or at once while EN is low.
// Optional feature macro: PWM_CENTER_EN builds center-aligned (up/down) mode.
// Without it, CENTER is accepted but ignored and the counter is edge-aligned only.
module pwm_multi #(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = 8,
  parameter int DEFAULT_PERIOD = 100,
  parameter int DEFAULT_DUTY   = 30
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      LOAD,
  input  logic [CNT_W-1:0]          PERIOD_IN,
  input  logic [CHANNELS*CNT_W-1:0] DUTY_IN,
  input  logic                      CENTER,
  output logic                      BUSY,
  output logic                      WRAP,
  output logic [CHANNELS-1:0]       OUT
);

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DUTY_RST   = CNT_W'(DEFAULT_DUTY);
  localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0]                cnt_reg, cnt_next;
  logic [CNT_W-1:0]                period_act_reg, period_sh_reg;
  logic [CHANNELS-1:0][CNT_W-1:0]  duty_act_reg, duty_sh_reg;
  logic                            busy_reg, busy_next;
  logic [CHANNELS-1:0]             out_reg, out_next;
  logic                            wrap;
  logic                            commit;
  logic [CNT_W-1:0]                period_last;
  logic [CNT_W-1:0]                period_clamped;

`ifdef PWM_CENTER_EN
  logic                            dir_down_reg, dir_down_next;
  logic                            center_act_reg, center_sh_reg;
`else
  logic                            unused_center;
  assign unused_center = CENTER;
`endif

  // Last count value of the up ramp; period is never below 2, so no underflow.
  assign period_last    = period_act_reg - ONE;
  // Periods below 2 would leave no room for a low phase; clamp at capture.
  assign period_clamped = (PERIOD_IN < PERIOD_MIN) ? PERIOD_MIN : PERIOD_IN;

`ifdef PWM_CENTER_EN
  assign wrap = EN & (center_act_reg ? (dir_down_reg & (cnt_reg == '0))
                                     : (cnt_reg == period_last));
`else
  assign wrap = EN & (cnt_reg == period_last);
`endif

  // While stopped there is no period boundary to wait for, so commit at once.
  assign commit = busy_reg & (~EN | wrap);

  // Next counter value: restart at 0 on wrap or when stopped.
  always_comb begin
    cnt_next = cnt_reg;
`ifdef PWM_CENTER_EN
    dir_down_next = dir_down_reg;
`endif
    if (!EN || wrap) begin
      cnt_next = '0;
`ifdef PWM_CENTER_EN
      dir_down_next = 1'b0;
`endif
    end else begin
`ifdef PWM_CENTER_EN
      if (!center_act_reg) begin
        cnt_next = cnt_reg + ONE;
      end else if (!dir_down_reg) begin
        // Top value is held one extra cycle while turning around.
        if (cnt_reg == period_last) begin
          dir_down_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end else begin
        cnt_next = cnt_reg - ONE;
      end
`else
      cnt_next = cnt_reg + ONE;
`endif
    end
  end

  // A new LOAD always leaves something pending, even on a commit edge.
  always_comb begin
    busy_next = busy_reg;
    if (LOAD) begin
      busy_next = 1'b1;
    end else if (commit) begin
      busy_next = 1'b0;
    end
  end

  // Per-channel compare against the active duty.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cmp
    assign out_next[gi] = EN & (cnt_reg < duty_act_reg[gi]);
  end

  // Counter, period, busy flag and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg        <= '0;
      period_act_reg <= PERIOD_RST;
      period_sh_reg  <= PERIOD_RST;
      busy_reg       <= 1'b0;
      out_reg        <= '0;
    end else begin
      cnt_reg  <= cnt_next;
      busy_reg <= busy_next;
      out_reg  <= out_next;
      if (commit) begin
        period_act_reg <= period_sh_reg;
      end
      if (LOAD) begin
        period_sh_reg <= period_clamped;
      end
    end
  end

  // Per-channel duty shadow and active registers.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_duty
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        duty_act_reg[gi] <= DUTY_RST;
        duty_sh_reg[gi]  <= DUTY_RST;
      end else begin
        if (commit) begin
          duty_act_reg[gi] <= duty_sh_reg[gi];
        end
        if (LOAD) begin
          duty_sh_reg[gi] <= DUTY_IN[gi*CNT_W +: CNT_W];
        end
      end
    end
  end

`ifdef PWM_CENTER_EN
  // Direction flag and mode shadow/active bits for center-aligned counting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dir_down_reg   <= 1'b0;
      center_act_reg <= 1'b0;
      center_sh_reg  <= 1'b0;
    end else begin
      dir_down_reg <= dir_down_next;
      if (commit) begin
        center_act_reg <= center_sh_reg;
      end
      if (LOAD) begin
        center_sh_reg <= CENTER;
      end
    end
  end
`endif

  assign BUSY = busy_reg;
  assign WRAP = wrap;
  assign OUT  = out_reg;

endmodule
